// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM-stage access unit. Issues loads/stores from EX/MEM to the D-cache over a
// req/ready handshake, formats load data, builds store lanes and byte enables,
// and stalls the upstream pipeline (with bubbles into MEM/WB) while an access
// is outstanding.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_in .. reg_write_in   EX/MEM instruction fields and controls
//   dc_req/we/addr/wdata/be    registered D-cache request
//   dc_ready, dc_rdata         D-cache accept/complete and read word
//   mem_data_out .. reg_write_out  MEM/WB inputs
//   mem_stall                  stall to the hazard unit
//   addr_err, bus_err          misaligned access / access timed out
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  dest_reg_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        dc_req,
    output logic        dc_we,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_be,
    input  logic        dc_ready,
    input  logic [31:0] dc_rdata,
    output logic [31:0] mem_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  dest_reg_out,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic        mem_stall,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit LP_TO_EN = (TIMEOUT_CYCLES != 0);
    // Counter value seen during the last tolerated not-ready cycle.
    localparam logic [CNT_W-1:0] LP_TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [31:0]       r_hold;

    logic              w_memop;
    logic              w_misalign;
    logic              w_aligned_memop;

    // Byte enables for the lanes touched by the access.
    function automatic logic [3:0] f_store_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so the cache picks it up via dc_be.
    function automatic logic [31:0] f_store_wdata(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{sd[7:0]}};
            2'b01:   wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    // Select the addressed lane and sign/zero-extend it.
    function automatic logic [31:0] f_load_fmt(input logic [1:0] size, input logic [1:0] lo,
                                               input logic uns, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign w_memop         = valid_in & (mem_read_in | mem_write_in);
    assign w_aligned_memop = w_memop & ~w_misalign;
    assign alu_result_out  = alu_result_in;

    // Alignment check by access size (size 11 behaves as word).
    always_comb begin
        w_misalign = 1'b0;
        case (mem_size_in)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = alu_result_in[0];
            default: w_misalign = (alu_result_in[1:0] != 2'b00);
        endcase
    end

    // Access FSM: owns the registered cache request, wait counter, error flag and read hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_hold   <= 32'h0000_0000;
            dc_req   <= 1'b0;
            dc_we    <= 1'b0;
            dc_addr  <= 32'h0000_0000;
            dc_wdata <= 32'h0000_0000;
            dc_be    <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aligned_memop) begin
                        r_state  <= ST_ACCESS;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                        dc_req   <= 1'b1;
                        dc_we    <= mem_write_in;   // store wins over load
                        dc_addr  <= {alu_result_in[31:2], 2'b00};
                        dc_wdata <= f_store_wdata(mem_size_in, store_data_in);
                        dc_be    <= f_store_be(mem_size_in, alu_result_in[1:0]);
                    end
                end
                ST_ACCESS: begin
                    if (dc_ready) begin
                        r_hold  <= dc_rdata;
                        dc_req  <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (LP_TO_EN && (r_cnt == LP_TO_LAST)) begin
                        dc_req  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    dc_req  <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB outputs, stall and error flags derived from state and the live EX/MEM fields.
    // EX/MEM is frozen while stalled, so in DONE the inputs still describe the memop.
    always_comb begin
        mem_stall      = 1'b0;
        addr_err       = 1'b0;
        bus_err        = 1'b0;
        mem_data_out   = 32'h0000_0000;
        dest_reg_out   = dest_reg_in;
        mem_to_reg_out = mem_to_reg_in;
        reg_write_out  = reg_write_in;
        case (r_state)
            ST_IDLE: begin
                if (w_aligned_memop) begin
                    // The instruction reaches MEM/WB only in DONE; bubble now.
                    mem_stall      = 1'b1;
                    dest_reg_out   = 5'd0;
                    mem_to_reg_out = 1'b0;
                    reg_write_out  = 1'b0;
                end else if (w_memop) begin
                    addr_err      = 1'b1;
                    reg_write_out = 1'b0;
                end else begin
                    mem_stall = 1'b0;
                end
            end
            ST_ACCESS: begin
                mem_stall      = 1'b1;
                dest_reg_out   = 5'd0;
                mem_to_reg_out = 1'b0;
                reg_write_out  = 1'b0;
            end
            ST_DONE: begin
                mem_data_out = f_load_fmt(mem_size_in, alu_result_in[1:0], mem_unsigned_in, r_hold);
                if (r_err) begin
                    bus_err       = 1'b1;
                    reg_write_out = 1'b0;
                end else begin
                    bus_err = 1'b0;
                end
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// memops checked against an arithmetic reference model. A second instance with
// TIMEOUT_CYCLES=4 and dc_ready tied low exercises the bus timeout.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_in, mem_read_in, mem_write_in, mem_unsigned_in;
    logic        mem_to_reg_in, reg_write_in, dc_ready;
    logic [31:0] alu_result_in, store_data_in, dc_rdata;
    logic [4:0]  dest_reg_in;
    logic [1:0]  mem_size_in;

    logic        dc_req, dc_we, mem_to_reg_out, reg_write_out, mem_stall, addr_err, bus_err;
    logic [31:0] dc_addr, dc_wdata, mem_data_out, alu_result_out;
    logic [3:0]  dc_be;
    logic [4:0]  dest_reg_out;

    logic        dc_req_t, dc_we_t, mem_to_reg_out_t, reg_write_out_t, mem_stall_t, addr_err_t, bus_err_t;
    logic [31:0] dc_addr_t, dc_wdata_t, mem_data_out_t, alu_result_out_t;
    logic [3:0]  dc_be_t;
    logic [4:0]  dest_reg_out_t;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_stage u_dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .dest_reg_in(dest_reg_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .dc_req(dc_req), .dc_we(dc_we),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_be(dc_be), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_data_out(mem_data_out), .alu_result_out(alu_result_out), .dest_reg_out(dest_reg_out),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .mem_stall(mem_stall),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    mem_access_stage #(.TIMEOUT_CYCLES(4)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .dest_reg_in(dest_reg_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .dc_req(dc_req_t), .dc_we(dc_we_t),
        .dc_addr(dc_addr_t), .dc_wdata(dc_wdata_t), .dc_be(dc_be_t), .dc_ready(1'b0), .dc_rdata(32'h0000_0000),
        .mem_data_out(mem_data_out_t), .alu_result_out(alu_result_out_t), .dest_reg_out(dest_reg_out_t),
        .mem_to_reg_out(mem_to_reg_out_t), .reg_write_out(reg_write_out_t), .mem_stall(mem_stall_t),
        .addr_err(addr_err_t), .bus_err(bus_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] addr);
        return (int'(addr[1:0]) % m_nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
        int mask;
        mask = (1 << m_nbytes(sz)) - 1;
        return 4'(mask << int'(addr[1:0]));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
        int nb;
        nb = m_nbytes(sz);
        if (nb == 1) return (sd & 32'h0000_00FF) * 32'h0101_0101;
        if (nb == 2) return (sd & 32'h0000_FFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] addr,
                                           input bit uns, input logic [31:0] w);
        logic [63:0] v;
        int nb;
        nb = m_nbytes(sz);
        v = {32'h0000_0000, w} >> (8 * int'(addr[1:0]));
        v = v & ((64'd1 << (8 * nb)) - 64'd1);
        if (!uns && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_idle();
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; mem_size_in = 2'b00;
        mem_unsigned_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
        alu_result_in = 32'h0; store_data_in = 32'h0; dest_reg_in = 5'd0;
        dc_ready = 1'b0; dc_rdata = 32'h0;
    endtask

    // Full aligned memop on u_dut; ready rises on ACCESS cycle number `delay`.
    task automatic run_memop(input bit st, input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] sd, input bit uns, input int delay,
                             input logic [31:0] rdata, output logic [31:0] got_data,
                             output logic [3:0] got_be, output logic [31:0] got_wdata);
        logic [4:0] dr;
        bit rw, mtr, rd_too, done;
        int stalls;
        dr = 5'($urandom_range(1, 31));
        rw = 1'($urandom_range(0, 1)) | !st;
        mtr = !st;
        rd_too = st ? 1'($urandom_range(0, 1)) : 1'b1;
        stalls = 0; done = 1'b0;
        got_data = 32'h0; got_be = 4'h0; got_wdata = 32'h0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            valid_in = 1'b1; mem_read_in = rd_too; mem_write_in = st; mem_size_in = sz;
            mem_unsigned_in = uns; mem_to_reg_in = mtr; reg_write_in = rw;
            alu_result_in = addr; store_data_in = sd; dest_reg_in = dr;
            dc_ready = (c == 0) ? 1'($urandom_range(0, 1)) : (c - 1 >= delay);
            dc_rdata = (c - 1 == delay) ? rdata : $urandom;
            #1;
            if (mem_stall) begin
                stalls++;
                check_eq("bubble", {25'd0, reg_write_out, mem_to_reg_out, dest_reg_out}, 32'h0);
                if (c >= 1) begin
                    check_eq("dc_req_held", {31'd0, dc_req}, 32'h1);
                    check_eq("dc_addr_held", dc_addr, {addr[31:2], 2'b00});
                    check_eq("dc_we", {31'd0, dc_we}, {31'd0, st});
                    if (st) begin
                        check_eq("dc_be", {28'd0, dc_be}, {28'd0, m_be(sz, addr)});
                        check_eq("dc_wdata", dc_wdata, m_wdata(sz, sd));
                    end
                    if (c == 1) begin
                        got_be = dc_be; got_wdata = dc_wdata;
                    end
                end else begin
                    check_eq("dc_req_idle", {31'd0, dc_req}, 32'h0);
                end
            end else begin
                done = 1'b1;
                check_eq("stall_cycles", 32'(stalls), 32'(2 + delay));
                check_eq("done_req_low", {31'd0, dc_req}, 32'h0);
                check_eq("done_bus_err", {31'd0, bus_err}, 32'h0);
                check_eq("done_ctrl", {25'd0, reg_write_out, mem_to_reg_out, dest_reg_out},
                         {25'd0, rw, mtr, dr});
                got_data = mem_data_out;
                if (!st) check_eq("load_data", mem_data_out, m_load(sz, addr, uns, rdata));
            end
        end
        if (!done) check_eq("memop_done_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_misaligned(input logic [1:0] sz, input logic [31:0] addr);
        @(negedge clk);
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'($urandom_range(0, 1));
        mem_size_in = sz; alu_result_in = addr; reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
        dest_reg_in = 5'd7; dc_ready = 1'b1;
        #1;
        check_eq("mis_addr_err", {31'd0, addr_err}, 32'h1);
        check_eq("mis_stall", {31'd0, mem_stall}, 32'h0);
        check_eq("mis_reg_write", {31'd0, reg_write_out}, 32'h0);
        check_eq("mis_no_req", {31'd0, dc_req}, 32'h0);
        @(negedge clk);
        drive_idle();
        #1;
        check_eq("mis_stay_idle", {30'd0, dc_req, addr_err}, 32'h0);
    endtask

    task automatic run_nonmemop();
        logic [31:0] a;
        logic [4:0] d;
        bit rw, mtr, v;
        a = $urandom; d = 5'($urandom); rw = 1'($urandom); mtr = 1'($urandom);
        v = 1'($urandom);
        @(negedge clk);
        valid_in = v; mem_read_in = v ? 1'b0 : 1'($urandom); mem_write_in = v ? 1'b0 : 1'($urandom);
        mem_size_in = 2'($urandom); alu_result_in = a; dest_reg_in = d;
        reg_write_in = rw; mem_to_reg_in = mtr; dc_ready = 1'($urandom); dc_rdata = $urandom;
        #1;
        check_eq("np_stall_err", {30'd0, mem_stall, addr_err}, 32'h0);
        check_eq("np_data", mem_data_out, 32'h0);
        check_eq("np_alu", alu_result_out, a);
        check_eq("np_ctrl", {25'd0, reg_write_out, mem_to_reg_out, dest_reg_out}, {25'd0, rw, mtr, d});
    endtask

    initial begin
        logic [31:0] gd, gw, addr;
        logic [3:0]  gb;
        logic [1:0]  sz;
        int kind, stalls;
        bit done;

        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_req_we", {30'd0, dc_req, dc_we}, 32'h0);
        check_eq("rst_addr", dc_addr, 32'h0);
        check_eq("rst_wdata", dc_wdata, 32'h0);
        check_eq("rst_be", {28'd0, dc_be}, 32'h0);
        check_eq("rst_stall", {31'd0, mem_stall}, 32'h0);

        // Directed cases.
        run_memop(1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, gd, gb, gw);
        check_eq("lw_0x100", gd, 32'hDEAD_BEEF);
        run_memop(1'b0, 2'b00, 32'h0000_0103, 32'h0, 1'b0, 0, 32'h80FF_1234, gd, gb, gw);
        check_eq("lb_0x103", gd, 32'hFFFF_FF80);
        run_memop(1'b0, 2'b00, 32'h0000_0103, 32'h0, 1'b1, 0, 32'h80FF_1234, gd, gb, gw);
        check_eq("lbu_0x103", gd, 32'h0000_0080);
        run_memop(1'b0, 2'b01, 32'h0000_0102, 32'h0, 1'b1, 1, 32'h80FF_1234, gd, gb, gw);
        check_eq("lhu_0x102", gd, 32'h0000_80FF);
        run_memop(1'b1, 2'b00, 32'h0000_0101, 32'h0000_00AB, 1'b0, 0, 32'h0, gd, gb, gw);
        check_eq("sb_be", {28'd0, gb}, 32'h0000_0002);
        check_eq("sb_wdata", gw, 32'hABAB_ABAB);
        run_memop(1'b1, 2'b01, 32'h0000_0102, 32'h1234_5678, 1'b0, 0, 32'h0, gd, gb, gw);
        check_eq("sh_be", {28'd0, gb}, 32'h0000_000C);
        run_memop(1'b0, 2'b10, 32'h0000_0100, 32'h0, 1'b0, 5, 32'h0BAD_F00D, gd, gb, gw);
        run_misaligned(2'b10, 32'h0000_0102);
        run_nonmemop();

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            sz = 2'($urandom);
            addr = $urandom;
            if (kind <= 6) begin
                addr[1:0] = (m_nbytes(sz) == 1) ? addr[1:0] : ((m_nbytes(sz) == 2) ? {addr[1], 1'b0} : 2'b00);
                run_memop(kind >= 4, sz, addr, $urandom, 1'($urandom), $urandom_range(0, 4),
                          $urandom, gd, gb, gw);
            end else if (kind == 7) begin
                sz = 2'($urandom_range(1, 3));
                addr[0] = 1'b1;
                if (m_misaligned(sz, addr)) run_misaligned(sz, addr);
            end else begin
                run_nonmemop();
            end
        end

        // Let the timeout instance settle in IDLE.
        repeat (10) begin
            @(negedge clk);
            drive_idle();
        end

        // Timeout on the TIMEOUT_CYCLES=4 instance: 1 IDLE + 4 ACCESS stall cycles.
        stalls = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; mem_size_in = 2'b10;
            alu_result_in = 32'h0000_0200; dest_reg_in = 5'd9; reg_write_in = 1'b1;
            mem_to_reg_in = 1'b1; dc_ready = 1'b0;
            #1;
            if (mem_stall_t) begin
                stalls++;
                if (c >= 1) check_eq("to_req_held", {31'd0, dc_req_t}, 32'h1);
            end else begin
                done = 1'b1;
                check_eq("to_stall_cycles", 32'(stalls), 32'd5);
                check_eq("to_bus_err", {31'd0, bus_err_t}, 32'h1);
                check_eq("to_reg_write", {31'd0, reg_write_out_t}, 32'h0);
                check_eq("to_req_dropped", {31'd0, dc_req_t}, 32'h0);
            end
        end
        if (!done) check_eq("to_done_timeout", 32'h0, 32'h1);

        // u_dut (long timeout) is still waiting in ACCESS; reset it mid-access.
        check_eq("pre_rst_req", {31'd0, dc_req}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req", {31'd0, dc_req}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        #1;
        check_eq("post_rst_idle", {30'd0, dc_req, mem_stall}, 32'h0);
        run_memop(1'b0, 2'b10, 32'h0000_0040, 32'h0, 1'b0, 0, 32'h1357_9BDF, gd, gb, gw);
        check_eq("post_rst_lw", gd, 32'h1357_9BDF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
